// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, widths and slot state type
package alu_pkg;

  localparam int CTRL_W     = 3;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD = 3'd0;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'd1;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'd2;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'd3;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'd4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - two-port request/response bundle of the shared ALU
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);

  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [2*DATA_W-1:0] req_a_i;
  logic [2*DATA_W-1:0] req_b_i;
  logic [2*CTRL_W-1:0] req_ctrl_i;
  logic [2*TAG_W-1:0]  req_tag_i;
  logic [1:0]          rsp_valid_o;
  logic [1:0]          rsp_ready_i;
  logic [2*DATA_W-1:0] rsp_data_o;
  logic [1:0]          rsp_zero_o;
  logic [2*TAG_W-1:0]  rsp_tag_o;
  logic                prio_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_ctrl_i, req_tag_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_tag_o, prio_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_ctrl_i, req_tag_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_tag_o, prio_o
  );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 5-op integer ALU with zero flag
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin time-sharing of one ALU between two
// requesters, with a registered single-entry result slot per port
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  slot_state_e         slot_q [2];
  logic [2*DATA_W-1:0] data_q;
  logic [1:0]          zero_q;
  logic [2*TAG_W-1:0]  tag_q;
  logic                prio_q;

  logic [1:0]          rsp_valid;
  logic [1:0]          eligible;
  logic [1:0]          grant;
  logic                sel;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [CTRL_W-1:0]   sel_ctrl;
  logic [TAG_W-1:0]    sel_tag;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;

  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < 2; k++) begin
      rsp_valid[k] = (slot_q[k] == SLOT_FULL);
    end
  end

  // A slot being drained this cycle can take a new result at the same edge.
  assign eligible = bus.req_valid_i & (~rsp_valid | bus.rsp_ready_i);

  always_comb begin
    grant = '0;
    if (!rst_n) begin
      grant = '0;
    end else if (&eligible) begin
      grant[prio_q] = 1'b1;
    end else begin
      grant = eligible;
    end
  end

  // Port 0 is the idle default so the ALU never sees an undriven operand.
  assign sel      = grant[1];
  assign sel_a    = sel ? bus.req_a_i[DATA_W +: DATA_W]    : bus.req_a_i[0 +: DATA_W];
  assign sel_b    = sel ? bus.req_b_i[DATA_W +: DATA_W]    : bus.req_b_i[0 +: DATA_W];
  assign sel_ctrl = sel ? bus.req_ctrl_i[CTRL_W +: CTRL_W] : bus.req_ctrl_i[0 +: CTRL_W];
  assign sel_tag  = sel ? bus.req_tag_i[TAG_W +: TAG_W]    : bus.req_tag_i[0 +: TAG_W];

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .a      (sel_a),
    .b      (sel_b),
    .ctrl   (sel_ctrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        slot_q[k] <= SLOT_EMPTY;
      end
      data_q <= '0;
      zero_q <= '0;
      tag_q  <= '0;
      prio_q <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (grant[k]) begin
          slot_q[k]                     <= SLOT_FULL;
          data_q[k*DATA_W +: DATA_W]    <= alu_result;
          zero_q[k]                     <= alu_zero;
          tag_q[k*TAG_W +: TAG_W]       <= sel_tag;
        end else if (slot_q[k] == SLOT_FULL && bus.rsp_ready_i[k]) begin
          slot_q[k] <= SLOT_EMPTY;
        end
      end
      if (|grant) begin
        prio_q <= ~sel;
      end
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_zero_o  = zero_q;
  assign bus.rsp_tag_o   = tag_q;
  assign bus.prio_o      = prio_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk_i;
  logic rst_n;
  int   checks;
  int   errors;

  alu_share_arbiter_if #(.DATA_W(32), .TAG_W(4)) bus ();

  alu_share_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int port, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    bus.req_a_i[port*32 +: 32]  = a;
    bus.req_b_i[port*32 +: 32]  = b;
    bus.req_ctrl_i[port*3 +: 3] = ctrl;
    bus.req_tag_i[port*4 +: 4]  = tag;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b00;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.req_ctrl_i = '0;
    bus.req_tag_i = '0;

    // Reset state, with requests present to show ready is held low
    #2;
    bus.req_valid_i = 2'b11;
    #1;
    check("rst_ready", bus.req_ready_o, 2'b00);
    check("rst_valid", bus.rsp_valid_o, 2'b00);
    check("rst_data",  bus.rsp_data_o, 64'h0);
    check("rst_zero",  bus.rsp_zero_o, 2'b00);
    check("rst_tag",   bus.rsp_tag_o, 8'h00);
    check("rst_prio",  bus.prio_o, 1'b0);
    bus.req_valid_i = 2'b00;
    step();
    rst_n = 1'b1;

    // Single ADD on port 0
    step();
    drive(0, ALU_ADD, 32'd5, 32'd7, 4'd3);
    bus.req_valid_i = 2'b01;
    #1;
    check("t1_ready", bus.req_ready_o, 2'b01);
    step();
    bus.req_valid_i = 2'b00;
    check("t1_valid", bus.rsp_valid_o, 2'b01);
    check("t1_data0", bus.rsp_data_o[31:0], 32'd12);
    check("t1_zero0", bus.rsp_zero_o[0], 1'b0);
    check("t1_tag0",  bus.rsp_tag_o[3:0], 4'd3);
    check("t1_prio",  bus.prio_o, 1'b1);
    bus.rsp_ready_i = 2'b01;
    step();
    check("t1_drain", bus.rsp_valid_o, 2'b00);

    // Contention from reset: grants alternate
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t2_prio0", bus.prio_o, 1'b0);
    drive(0, ALU_SUB, 32'd9, 32'd9, 4'd1);
    drive(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2);
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b11;
    #1;
    check("t2_g0", bus.req_ready_o, 2'b01);
    step();
    check("t2_v0",    bus.rsp_valid_o, 2'b01);
    check("t2_data0", bus.rsp_data_o[31:0], 32'd0);
    check("t2_zero0", bus.rsp_zero_o[0], 1'b1);
    check("t2_prio1", bus.prio_o, 1'b1);
    check("t2_g1",    bus.req_ready_o, 2'b10);
    step();
    check("t2_v1",    bus.rsp_valid_o, 2'b10);
    check("t2_data1", bus.rsp_data_o[63:32], 32'd1);
    check("t2_zero1", bus.rsp_zero_o[1], 1'b0);
    check("t2_tag1",  bus.rsp_tag_o[7:4], 4'd2);
    check("t2_prio2", bus.prio_o, 1'b0);
    check("t2_g2",    bus.req_ready_o, 2'b01);
    step();
    check("t2_v2",    bus.rsp_valid_o, 2'b01);
    check("t2_prio3", bus.prio_o, 1'b1);
    bus.req_valid_i = 2'b00;
    step();

    // Backpressure on port 0 while port 1 streams
    drive(0, ALU_ADD, 32'd100, 32'd23, 4'd5);
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b00;
    step();
    check("t3_full0", bus.rsp_data_o[31:0], 32'd123);
    drive(0, ALU_ADD, 32'd1, 32'd1, 4'd6);
    drive(1, ALU_ADD, 32'd2, 32'd3, 4'd7);
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_ready", bus.req_ready_o, 2'b10);
      check("t3_hold0", bus.rsp_data_o[31:0], 32'd123);
      check("t3_vld0",  bus.rsp_valid_o[0], 1'b1);
      step();
    end
    check("t3_data1", bus.rsp_data_o[63:32], 32'd5);
    bus.rsp_ready_i = 2'b11;
    #1;
    check("t3_release", bus.req_ready_o, 2'b01);
    step();
    check("t3_data0", bus.rsp_data_o[31:0], 32'd2);
    check("t3_tag0",  bus.rsp_tag_o[3:0], 4'd6);
    bus.req_valid_i = 2'b00;
    step();

    // Back-to-back on port 1
    bus.req_valid_i = 2'b10;
    bus.rsp_ready_i = 2'b11;
    drive(1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 4'd1);
    #1;
    check("t4_ready", bus.req_ready_o, 2'b10);
    step();
    drive(1, ALU_OR, 32'h0000_000F, 32'h0000_00F0, 4'd2);
    check("t4_and", bus.rsp_data_o[63:32], 32'h0000_F000);
    #1;
    check("t4_ready2", bus.req_ready_o, 2'b10);
    step();
    drive(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3);
    check("t4_or", bus.rsp_data_o[63:32], 32'h0000_00FF);
    step();
    check("t4_add",  bus.rsp_data_o[63:32], 32'd0);
    check("t4_zero", bus.rsp_zero_o[1], 1'b1);
    check("t4_vld",  bus.rsp_valid_o[1], 1'b1);
    check("t4_tag",  bus.rsp_tag_o[7:4], 4'd3);
    bus.req_valid_i = 2'b00;

    // Unassigned control code
    drive(0, 3'd6, 32'd3, 32'd4, 4'd9);
    bus.req_valid_i = 2'b01;
    step();
    bus.req_valid_i = 2'b00;
    check("t5_data", bus.rsp_data_o[31:0], 32'd0);
    check("t5_zero", bus.rsp_zero_o[0], 1'b1);
    check("t5_tag",  bus.rsp_tag_o[3:0], 4'd9);

    // Asynchronous reset with both slots full
    bus.rsp_ready_i = 2'b00;
    bus.req_valid_i = 2'b11;
    step();
    check("t6_both", bus.rsp_valid_o, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_vld", bus.rsp_valid_o, 2'b00);
    check("t6_async_rdy", bus.req_ready_o, 2'b00);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready_i = 2'b11;
    #1;
    check("t6_first", bus.req_ready_o, 2'b01);
    check("t6_prio",  bus.prio_o, 1'b0);
    step();
    check("t6_vld", bus.rsp_valid_o, 2'b01);
    bus.req_valid_i = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
